// File: rtl/iot_mon_pkg.sv
// Shared definitions for the active-IoT-device monitor: default device count,
// the change/on_off event encoding and a popcount helper.
package iot_mon_pkg;

  localparam int N_DEV_DEFAULT = 8;

  // on_off only carries meaning while change is 1
  typedef enum logic {
    EV_DEC = 1'b0,
    EV_INC = 1'b1
  } ev_dir_e;

  typedef struct packed {
    logic    change;
    ev_dir_e on_off;
  } mon_event_t;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] acc;
    acc = '0;
    for (int i = 0; i < 64; i++) begin
      acc = acc + 7'(v[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/device_event_tx_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping modulo N_REQ. Returns both a one-hot grant and its index.
module rr_arbiter #(
  parameter  int N_REQ = 8,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/device_event_tx.sv
// Turns net changes on asynchronous device status lines into single-cycle
// increment/decrement events for the monitor counter, one per clock at most.
module device_event_tx
  import iot_mon_pkg::*;
#(
  parameter  int N_DEV = N_DEV_DEFAULT,
  localparam int PTR_W = $clog2(N_DEV),
  localparam int CNT_W = $clog2(N_DEV + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_status,
  input  logic             hold,
  output logic             change,
  output logic             on_off,
  output logic [CNT_W-1:0] pending,
  output logic             busy
);

  logic [N_DEV-1:0] sync1;
  logic [N_DEV-1:0] sync2;
  logic [N_DEV-1:0] reported;
  logic [N_DEV-1:0] mism;
  logic [N_DEV-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr;
  logic             gnt_valid;
  mon_event_t       ev_q;

  // reported mirrors what the monitor has counted, so any difference is owed
  assign mism    = sync2 ^ reported;
  assign pending = CNT_W'(popcount(64'(mism)));
  assign busy    = |mism;
  assign change  = ev_q.change;
  assign on_off  = ev_q.on_off;

  rr_arbiter #(
    .N_REQ(N_DEV)
  ) u_arb (
    .req      (mism),
    .ptr      (ptr),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= '0;
      sync2       <= '0;
      reported    <= '0;
      ptr         <= '0;
      ev_q.change <= 1'b0;
      ev_q.on_off <= EV_DEC;
    end else begin
      sync1 <= dev_status;
      sync2 <= sync1;
      if (!hold && gnt_valid) begin
        ev_q.change <= 1'b1;
        ev_q.on_off <= ev_dir_e'(sync2[gnt_idx]);
        reported    <= reported ^ gnt;
        ptr         <= (gnt_idx == PTR_W'(N_DEV - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        ev_q.change <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_device_event_tx.sv
// Self-checking bench for device_event_tx: directed vector table, reset
// mid-burst sequence and a randomized soak against a behavioural model.
module tb_device_event_tx;

  localparam int N = 8;

  typedef struct {
    logic [7:0] dev;
    logic       hold;
    logic       exp_change;
    logic       exp_on_off;
    int         exp_pending;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dev_status;
  logic       hold;
  logic       change;
  logic       on_off;
  logic [3:0] pending;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Behavioural model: two-sample delay line, set of reported devices,
  // round-robin start position and the monitor's running count.
  logic [7:0] m_s1, m_s2, m_rep;
  int         m_ptr;
  logic       m_change, m_oo;
  int         mon_cnt;

  vec_t vecs[$];

  always #5 clk = ~clk;

  device_event_tx #(.N_DEV(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .dev_status(dev_status),
    .hold      (hold),
    .change    (change),
    .on_off    (on_off),
    .pending   (pending),
    .busy      (busy)
  );

  function automatic int countOnes(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic void add(input logic [7:0] d, input logic h, input logic c,
                              input logic oo, input int p);
    vec_t v;
    v.dev = d; v.hold = h; v.exp_change = c; v.exp_on_off = oo; v.exp_pending = p;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_s1 = '0; m_s2 = '0; m_rep = '0; m_ptr = 0;
    m_change = 1'b0; m_oo = 1'b0; mon_cnt = 0;
  endtask

  // Drive inputs, take one clock edge, advance the model, compare.
  task automatic applyStimulus(input logic [7:0] d, input logic h);
    logic [7:0] owed;
    dev_status = d;
    hold       = h;
    @(posedge clk);
    if (!rst) begin
      modelReset();
    end else begin
      owed     = m_s2 ^ m_rep;
      m_change = 1'b0;
      if (!hold && owed != 0) begin
        for (int k = 0; k < N; k++) begin
          int dev = (m_ptr + k) % N;
          if (!m_change && owed[dev]) begin
            m_change   = 1'b1;
            m_oo       = m_s2[dev];
            m_rep[dev] = ~m_rep[dev];
            m_ptr      = (dev + 1) % N;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = dev_status;
    end
    #1;
    if (rst && change) mon_cnt += on_off ? 1 : -1;
    checkOutput("model_change", change, m_change);
    checkOutput("model_on_off", on_off, m_oo);
    checkOutput("model_pending", pending, countOnes(m_s2 ^ m_rep));
    checkOutput("model_busy", busy, (m_s2 != m_rep) ? 1 : 0);
    checkOutput("monitor_count", mon_cnt, countOnes(m_rep));
    checkOutput("count_in_range", (mon_cnt >= 0 && mon_cnt <= N) ? 1 : 0, 1);
  endtask

  initial begin
    logic [7:0] cur;
    int         exp_c[4];
    int         exp_p[4];

    // Reset release with all devices on, then drain to all off
    add(8'hFF, 0, 0, 0, 0);
    add(8'hFF, 0, 0, 0, 8);
    for (int i = 0; i < 8; i++) add(8'hFF, 0, 1, 1, 7 - i);
    add(8'hFF, 0, 0, 1, 0);
    add(8'h00, 0, 0, 1, 0);
    add(8'h00, 0, 0, 1, 8);
    for (int i = 0; i < 8; i++) add(8'h00, 0, 1, 0, 7 - i);
    add(8'h00, 0, 0, 0, 0);
    // Single toggle on device 2 and back
    add(8'h04, 0, 0, 0, 0); add(8'h04, 0, 0, 0, 1); add(8'h04, 0, 1, 1, 0); add(8'h04, 0, 0, 1, 0);
    add(8'h00, 0, 0, 1, 0); add(8'h00, 0, 0, 1, 1); add(8'h00, 0, 1, 0, 0); add(8'h00, 0, 0, 0, 0);
    // Device 5 on/off parks the pointer at 6
    add(8'h20, 0, 0, 0, 0); add(8'h20, 0, 0, 0, 1); add(8'h20, 0, 1, 1, 0); add(8'h20, 0, 0, 1, 0);
    add(8'h00, 0, 0, 1, 0); add(8'h00, 0, 0, 1, 1); add(8'h00, 0, 1, 0, 0); add(8'h00, 0, 0, 0, 0);
    // Round-robin wrap: grants 6, 0, 1
    add(8'h43, 0, 0, 0, 0); add(8'h43, 0, 0, 0, 3);
    add(8'h43, 0, 1, 1, 2); add(8'h43, 0, 1, 1, 1); add(8'h43, 0, 1, 1, 0);
    add(8'h43, 0, 0, 1, 0);
    // One-clock glitch on device 5 under hold leaves no event
    add(8'h63, 1, 0, 1, 0); add(8'h43, 1, 0, 1, 1); add(8'h43, 1, 0, 1, 0);
    add(8'h43, 1, 0, 1, 0); add(8'h43, 0, 0, 1, 0); add(8'h43, 0, 0, 1, 0);
    // Four devices rise under a 10-cycle hold
    add(8'h7F, 1, 0, 1, 0);
    for (int i = 0; i < 9; i++) add(8'h7F, 1, 0, 1, 4);
    add(8'h7F, 0, 1, 1, 3); add(8'h7F, 0, 1, 1, 2); add(8'h7F, 0, 1, 1, 1); add(8'h7F, 0, 1, 1, 0);
    add(8'h7F, 0, 0, 1, 0);
    // Hold in the middle of a decrement burst
    add(8'h00, 0, 0, 1, 0); add(8'h00, 0, 0, 1, 7); add(8'h00, 0, 1, 0, 6);
    add(8'h00, 1, 0, 0, 6); add(8'h00, 1, 0, 0, 6); add(8'h00, 0, 1, 0, 5);

    rst = 1'b0;
    dev_status = 8'hFF;
    hold = 1'b0;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hFF, 0);
      checkOutput("reset_change", change, 0);
      checkOutput("reset_pending", pending, 0);
    end
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dev, vecs[i].hold);
      checkOutput($sformatf("vec%0d_change", i), change, vecs[i].exp_change);
      checkOutput($sformatf("vec%0d_on_off", i), on_off, vecs[i].exp_on_off);
      checkOutput($sformatf("vec%0d_pending", i), pending, vecs[i].exp_pending);
    end

    // Asynchronous reset mid-burst discards the remaining decrements
    rst = 1'b0;
    #1;
    checkOutput("async_reset_change", change, 0);
    checkOutput("async_reset_pending", pending, 0);
    checkOutput("async_reset_busy", busy, 0);
    modelReset();
    applyStimulus(8'h05, 0);
    rst = 1'b1;
    exp_c = '{0, 0, 1, 1};
    exp_p = '{0, 2, 1, 0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h05, 0);
      checkOutput($sformatf("rereport%0d_change", i), change, exp_c[i]);
      checkOutput($sformatf("rereport%0d_pending", i), pending, exp_p[i]);
      if (exp_c[i] != 0) checkOutput($sformatf("rereport%0d_on_off", i), on_off, 1);
    end

    // Random soak: sparse bit flips give glitches and bursts, random hold
    cur = 8'h05;
    for (int i = 0; i < 10000; i++) begin
      cur = cur ^ 8'($urandom & $urandom & $urandom);
      applyStimulus(cur, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < N + 3; i++) applyStimulus(cur, 0);
    checkOutput("settled_count", mon_cnt, countOnes(cur));
    checkOutput("settled_pending", pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
